// File: rtl/snn_pkg.sv
// Shared packet definitions for the spiking-network datapath: packet types,
// field positions and the address map of the adder stage.
package snn_pkg;

    typedef enum logic [1:0] {
        PKT_MP    = 2'b10,
        PKT_SPIKE = 2'b11
    } pkt_type_e;

    localparam logic [12:0] DONE_TOKEN = 13'h000F;

    localparam int SRC_HI  = 63;
    localparam int SRC_LO  = 60;
    localparam int DST_HI  = 59;
    localparam int DST_LO  = 56;
    localparam int TYPE_HI = 55;
    localparam int TYPE_LO = 54;
    localparam int PAY_HI  = 12;
    localparam int PAY_LO  = 0;

    localparam int SPK_ROW_HI = 5;
    localparam int SPK_ROW_LO = 3;
    localparam int SPK_ADD_HI = 2;
    localparam int SPK_ADD_LO = 0;

    localparam logic [3:0] ADDER_BASE_ADDR = 4'h6;

endpackage

// File: rtl/mp_spike_writeback_mp_regfile.sv
// Membrane-potential storage: flop array with one write port and one registered
// read port; a read of the entry written on the same edge returns the new value.
module mp_regfile
    import snn_pkg::*;
#(
    parameter int DEPTH    = 25,
    parameter int MP_WIDTH = 13,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrEn,
    input  logic [IDX_W-1:0]    wrIdx,
    input  logic [MP_WIDTH-1:0] wrData,
    input  logic                rdEn,
    input  logic [IDX_W-1:0]    rdIdx,
    output logic [MP_WIDTH-1:0] rdData_p1,
    output logic                vld_p1
);

    logic [MP_WIDTH-1:0] mem [DEPTH];
    logic                rdInRange;

    assign rdInRange = int'(rdIdx) < DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdData_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            if (wrEn) begin
                mem[wrIdx] <= wrData;
            end
            vld_p1 <= rdEn;
            // p0 -> p1: read is registered; same-edge write to the same entry wins
            if (rdEn) begin
                if (wrEn && (wrIdx == rdIdx)) begin
                    rdData_p1 <= wrData;
                end else if (rdInRange) begin
                    rdData_p1 <= mem[rdIdx];
                end else begin
                    rdData_p1 <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mp_spike_writeback.sv
// Write-back sink for adder packets: stores potentials, builds the per-timestep
// spike bitmap and detects the end of a timestep from done tokens.
module mp_spike_writeback
    import snn_pkg::*;
#(
    parameter int         WIDTH           = 64,
    parameter int         MP_WIDTH        = 13,
    parameter int         NUM_ADDERS      = 5,
    parameter int         ROWS            = 5,
    parameter logic [3:0] ADDER_BASE_ADDR = snn_pkg::ADDER_BASE_ADDR,
    parameter int         IDX_W           = $clog2(NUM_ADDERS * ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       mp_rd_en,
    input  logic [IDX_W-1:0]           mp_rd_idx,
    output logic [MP_WIDTH-1:0]        mp_rd_data,
    output logic                       mp_rd_valid,
    output logic [NUM_ADDERS*ROWS-1:0] spike_map,
    output logic [IDX_W:0]             spike_count,
    output logic                       ts_done,
    input  logic                       ts_ack,
    output logic                       err_flag
);

    localparam int DEPTH  = NUM_ADDERS * ROWS;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADD_W  = $clog2(NUM_ADDERS);
    localparam int DONE_W = $clog2(ROWS + 1);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } wbState_e;

    wbState_e          state;
    logic [ROW_W-1:0]  rowCnt [NUM_ADDERS];
    logic [DONE_W-1:0] doneCnt;

    logic [3:0]        srcField;
    logic [1:0]        typeField;
    logic [12:0]       payload;
    logic [3:0]        adderFull;
    logic [ADD_W-1:0]  adderIdx;
    logic              adderOk;
    logic [2:0]        spkRow;
    logic [2:0]        spkAdd;
    logic              spikeOk;
    logic [IDX_W-1:0]  spkIdx;
    logic [IDX_W-1:0]  wrIdx;
    logic              accept;
    logic              mpWrEn;
    logic              unusedBits;

    assign srcField  = in_data[SRC_HI:SRC_LO];
    assign typeField = in_data[TYPE_HI:TYPE_LO];
    assign payload   = in_data[PAY_HI:PAY_LO];
    assign unusedBits = ^{in_data[DST_HI:DST_LO], in_data[TYPE_LO-1:PAY_HI+1]};

    // Source addresses below the base wrap to large values and fail the range test
    assign adderFull = srcField - ADDER_BASE_ADDR;
    assign adderOk   = int'(adderFull) < NUM_ADDERS;
    assign adderIdx  = adderFull[ADD_W-1:0];
    assign wrIdx     = IDX_W'(int'(rowCnt[adderIdx]) * NUM_ADDERS + int'(adderIdx));

    assign spkRow  = payload[SPK_ROW_HI:SPK_ROW_LO];
    assign spkAdd  = payload[SPK_ADD_HI:SPK_ADD_LO];
    assign spikeOk = (int'(spkRow) < ROWS) && (int'(spkAdd) < NUM_ADDERS);
    assign spkIdx  = IDX_W'(int'(spkRow) * NUM_ADDERS + int'(spkAdd));

    assign accept = in_valid & in_ready;
    assign mpWrEn = accept && (typeField == PKT_MP) && adderOk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            in_ready    <= 1'b1;
            ts_done     <= 1'b0;
            err_flag    <= 1'b0;
            spike_map   <= '0;
            spike_count <= '0;
            doneCnt     <= '0;
            for (int i = 0; i < NUM_ADDERS; i++) begin
                rowCnt[i] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        case (typeField)
                            PKT_MP: begin
                                if (!adderOk) begin
                                    err_flag <= 1'b1;
                                end else if (int'(rowCnt[adderIdx]) == ROWS - 1) begin
                                    rowCnt[adderIdx] <= '0;
                                end else begin
                                    rowCnt[adderIdx] <= rowCnt[adderIdx] + ROW_W'(1);
                                end
                            end
                            PKT_SPIKE: begin
                                if (payload == DONE_TOKEN) begin
                                    doneCnt <= doneCnt + DONE_W'(1);
                                    if (int'(doneCnt) == ROWS - 1) begin
                                        state    <= DONE;
                                        in_ready <= 1'b0;
                                        ts_done  <= 1'b1;
                                    end
                                end else if (!spikeOk) begin
                                    err_flag <= 1'b1;
                                end else if (!spike_map[spkIdx]) begin
                                    spike_map[spkIdx] <= 1'b1;
                                    spike_count       <= spike_count + (IDX_W + 1)'(1);
                                end
                            end
                            default: err_flag <= 1'b1;
                        endcase
                    end
                end
                DONE: begin
                    // Potentials are kept; only the per-timestep bookkeeping restarts
                    if (ts_ack) begin
                        state       <= RUN;
                        in_ready    <= 1'b1;
                        ts_done     <= 1'b0;
                        spike_map   <= '0;
                        spike_count <= '0;
                        doneCnt     <= '0;
                        for (int i = 0; i < NUM_ADDERS; i++) begin
                            rowCnt[i] <= '0;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    mp_regfile #(
        .DEPTH    (DEPTH),
        .MP_WIDTH (MP_WIDTH),
        .IDX_W    (IDX_W)
    ) uRegfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrEn      (mpWrEn),
        .wrIdx     (wrIdx),
        .wrData    (payload[MP_WIDTH-1:0]),
        .rdEn      (mp_rd_en),
        .rdIdx     (mp_rd_idx),
        .rdData_p1 (mp_rd_data),
        .vld_p1    (mp_rd_valid)
    );

endmodule

// File: tb/tb_mp_spike_writeback.sv
// Randomized and directed bench for mp_spike_writeback against a behavioural
// model of the potential store, spike bitmap and timestep handshake.
module tb_mp_spike_writeback;

    localparam int NA  = 5;
    localparam int NR  = 5;
    localparam int NN  = NA * NR;
    localparam int IW  = 5;

    logic          clk = 1'b0;
    logic          rstN;
    logic          inValid;
    logic          inReady;
    logic [63:0]   inData;
    logic          rdEn;
    logic [IW-1:0] rdIdx;
    logic [12:0]   rdData;
    logic          rdValid;
    logic [NN-1:0] spikeMap;
    logic [IW:0]   spikeCount;
    logic          tsDone;
    logic          tsAck;
    logic          errFlag;

    int checkCnt = 0;
    int passCnt  = 0;

    // behavioural model state
    int      mpM [NN];
    int      rcM [NA];
    int      dcM;
    bit [NN-1:0] smM;
    int      scM;
    bit      errM;
    bit      doneM;
    bit      rvM;
    int      rdM;

    always #5 clk = ~clk;

    mp_spike_writeback dut (
        .clk         (clk),
        .rst_n       (rstN),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .in_data     (inData),
        .mp_rd_en    (rdEn),
        .mp_rd_idx   (rdIdx),
        .mp_rd_data  (rdData),
        .mp_rd_valid (rdValid),
        .spike_map   (spikeMap),
        .spike_count (spikeCount),
        .ts_done     (tsDone),
        .ts_ack      (tsAck),
        .err_flag    (errFlag)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] mkPkt(input logic [3:0] s, input logic [1:0] t, input logic [12:0] p);
        logic [3:0]  dst;
        logic [40:0] mid;
        dst = 4'($urandom());
        mid = 41'({$urandom(), $urandom()});
        return {s, dst, t, mid, p};
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NN; i++) mpM[i] = 0;
        for (int i = 0; i < NA; i++) rcM[i] = 0;
        dcM = 0; smM = '0; scM = 0; errM = 0; doneM = 0; rvM = 0; rdM = 0;
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, "_rdy"},  32'(inReady),    32'(!doneM));
        checkVal({tag, "_done"}, 32'(tsDone),     32'(doneM));
        checkVal({tag, "_err"},  32'(errFlag),    32'(errM));
        checkVal({tag, "_map"},  32'(spikeMap),   32'(smM));
        checkVal({tag, "_cnt"},  32'(spikeCount), 32'(scM));
        checkVal({tag, "_rvld"}, 32'(rdValid),    32'(rvM));
        if (rvM) checkVal({tag, "_rdat"}, 32'(rdData), 32'(rdM));
    endtask

    // One clock: apply the rules to the current inputs, then compare after the edge
    task automatic tick(input string tag);
        int src, typ, pay, a, row, ad, b;
        if (inValid && !doneM) begin
            src = int'(inData[63:60]);
            typ = int'(inData[55:54]);
            pay = int'(inData[12:0]);
            if (typ == 2) begin
                a = (src - 6) & 15;
                if (a < NA) begin
                    mpM[rcM[a] * NA + a] = pay;
                    rcM[a] = (rcM[a] + 1) % NR;
                end else errM = 1;
            end else if (typ == 3) begin
                if (pay == 15) begin
                    dcM++;
                    if (dcM == NR) doneM = 1;
                end else begin
                    row = (pay >> 3) & 7;
                    ad  = pay & 7;
                    if (row < NR && ad < NA) begin
                        b = row * NA + ad;
                        if (!smM[b]) begin smM[b] = 1'b1; scM++; end
                    end else errM = 1;
                end
            end else errM = 1;
        end else if (doneM && tsAck) begin
            smM = '0; scM = 0; dcM = 0; doneM = 0;
            for (int i = 0; i < NA; i++) rcM[i] = 0;
        end
        rvM = rdEn;
        if (rdEn) rdM = (int'(rdIdx) < NN) ? mpM[rdIdx] : 0;
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic sendPkt(input string tag, input logic [63:0] d);
        inValid = 1'b1;
        inData  = d;
        tick(tag);
        inValid = 1'b0;
    endtask

    task automatic readChk(input string tag, input int idx, input int exp);
        rdEn  = 1'b1;
        rdIdx = IW'(idx);
        tick(tag);
        rdEn  = 1'b0;
        checkVal(tag, 32'(rdData), 32'(exp));
    endtask

    task automatic midReset(input string tag);
        rstN = 1'b0;
        #1;
        checkVal({tag, "_rdy"},  32'(inReady),    32'd1);
        checkVal({tag, "_done"}, 32'(tsDone),     32'd0);
        checkVal({tag, "_err"},  32'(errFlag),    32'd0);
        checkVal({tag, "_map"},  32'(spikeMap),   32'd0);
        checkVal({tag, "_cnt"},  32'(spikeCount), 32'd0);
        checkVal({tag, "_rvld"}, 32'(rdValid),    32'd0);
        resetModel();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        int r;
        logic [3:0]  s;
        logic [12:0] p;
        rstN = 1'b0; inValid = 1'b0; inData = '0; rdEn = 1'b0; rdIdx = '0; tsAck = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_rdy", 32'(inReady), 32'd1);
        checkVal("rst_done", 32'(tsDone), 32'd0);
        checkVal("rst_err", 32'(errFlag), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // reset contents
        for (int i = 0; i < NN; i++) readChk("t1_rd", i, 0);

        // adder 2 (src 8) writes rows 0..2, then wraps on the sixth write
        sendPkt("t2_w", mkPkt(4'h8, 2'b10, 13'd1));
        sendPkt("t2_w", mkPkt(4'h8, 2'b10, 13'd2));
        sendPkt("t2_w", mkPkt(4'h8, 2'b10, 13'd3));
        readChk("t2_idx2", 2, 1);
        readChk("t2_idx7", 7, 2);
        readChk("t2_idx12", 12, 3);
        sendPkt("t2_w", mkPkt(4'h8, 2'b10, 13'd4));
        sendPkt("t2_w", mkPkt(4'h8, 2'b10, 13'd5));
        sendPkt("t2_w", mkPkt(4'h8, 2'b10, 13'd6));
        readChk("t2_wrap", 2, 6);

        // duplicate spike on neuron 9
        sendPkt("t3_s", mkPkt(4'h8, 2'b11, 13'd12));
        sendPkt("t3_s", mkPkt(4'h8, 2'b11, 13'd12));
        checkVal("t3_bit9", 32'(spikeMap), 32'h200);
        checkVal("t3_cnt", 32'(spikeCount), 32'd1);

        // end of timestep
        for (int i = 0; i < NR; i++) sendPkt("t4_tok", mkPkt(4'h7, 2'b11, 13'h000F));
        checkVal("t4_done", 32'(tsDone), 32'd1);
        checkVal("t4_rdy", 32'(inReady), 32'd0);
        inValid = 1'b1;
        inData  = mkPkt(4'h8, 2'b10, 13'h0AAA);
        repeat (3) tick("t4_hold");
        inValid = 1'b0;
        tsAck = 1'b1;
        tick("t4_ack");
        tsAck = 1'b0;
        checkVal("t4_rdy_after", 32'(inReady), 32'd1);
        checkVal("t4_map_clr", 32'(spikeMap), 32'd0);
        readChk("t4_keep", 2, 6);

        // errors leave state unchanged
        sendPkt("t5_src", mkPkt(4'hF, 2'b10, 13'h0055));
        sendPkt("t5_typ", mkPkt(4'h8, 2'b01, 13'h0055));
        sendPkt("t5_row", mkPkt(4'h8, 2'b11, 13'd48));
        checkVal("t5_err", 32'(errFlag), 32'd1);
        readChk("t5_keep", 7, 2);

        // bypass: adder 3 row 0 is neuron 3
        inValid = 1'b1;
        inData  = mkPkt(4'h9, 2'b10, 13'h1FFF);
        rdEn    = 1'b1;
        rdIdx   = IW'(3);
        tick("t6_byp");
        inValid = 1'b0;
        rdEn    = 1'b0;
        checkVal("t6_byp", 32'(rdData), 32'h1FFF);
        sendPkt("t6_s", mkPkt(4'h8, 2'b11, 13'd3));
        midReset("t6_rst");
        readChk("t6_cleared", 3, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) midReset("rnd_rst");
            inValid = ($urandom_range(0, 99) < 70);
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                s = ($urandom_range(0, 99) < 92) ? 4'(6 + $urandom_range(0, 4)) : 4'($urandom());
                inData = mkPkt(s, 2'b10, 13'($urandom()));
            end else if (r < 78) begin
                p = {7'd0, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
                inData = mkPkt(4'($urandom()), 2'b11, p);
            end else if (r < 97) begin
                inData = mkPkt(4'($urandom()), 2'b11, 13'h000F);
            end else begin
                inData = mkPkt(4'h8, 2'($urandom_range(0, 1)), 13'($urandom()));
            end
            tsAck = ($urandom_range(0, 99) < 25);
            rdEn  = ($urandom_range(0, 99) < 60);
            rdIdx = IW'($urandom_range(0, 31));
            tick("rnd");
        end
        inValid = 1'b0; tsAck = 1'b0; rdEn = 1'b0;

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
